norm_shift_ctrl: RTL and testbench
==================================

NORM_SHIFT_CTRL -- requirements
Module: norm_shift_ctrl

Interface
REQ-001 Parameter DataWidth, default 24: mantissa width in bits.
REQ-002 Parameter ExpWidth, default 8: exponent width in bits.
REQ-003 Parameter StepShift, default 7: maximum left shift per cycle; the shift-amount field width SHALL be $clog2(StepShift+1).
REQ-004 clk_i  input  1  clock; all state SHALL update on the rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 valid_i  input  1  input operand valid.
REQ-007 ready_o  output  1  block can accept an operand.
REQ-008 mant_i  input  DataWidth  unnormalized mantissa.
REQ-009 exp_i  input  ExpWidth  biased exponent of mant_i.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  downstream accepts the result.
REQ-012 mant_o  output  DataWidth  normalized mantissa.
REQ-013 exp_o  output  ExpWidth  adjusted exponent.
REQ-014 shift_count_o  output  $clog2(DataWidth+1)  total left shift applied.
REQ-015 zero_o  output  1  the input mantissa was zero.
REQ-016 underflow_o  output  1  normalization stopped by the exponent clamp (non-zero mant_o with MSB 0).

Function
REQ-017 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-018 ready_o SHALL equal (state==IDLE), and valid_o SHALL equal (state==DONE).
REQ-019 In IDLE, when valid_i=1, the block SHALL capture mant_i and exp_i, clear the shift count and go to SHIFT.
REQ-020 In SHIFT, the block SHALL compute lz as the leading-zero count of the held mantissa, in the range 0..DataWidth.
REQ-021 In SHIFT, the block SHALL compute step = min(lz, StepShift, exp>0 ? exp-1 : 0).
REQ-022 In SHIFT with a held mantissa of zero, the block SHALL force exp to 0, set zero, and go to DONE without shifting.
REQ-023 In SHIFT with step>0, the block SHALL shift the mantissa left by step, decrement exp by step, add step to the count, and stay in SHIFT.
REQ-024 In SHIFT with step=0, the block SHALL go to DONE without changing the held data.
REQ-025 valid_o SHALL first assert ceil(S/StepShift)+1 cycles after the accept edge, where S is the total shift applied.
REQ-026 In DONE, all outputs SHALL be held stable until ready_i=1, after which the block SHALL return to IDLE on the next edge.
REQ-027 The block SHALL NOT accept an operand in SHIFT or DONE, so there is no simultaneous accept and release.
REQ-028 underflow_o SHALL be 1 in DONE when the mantissa is non-zero and its MSB is 0.
REQ-029 The exponent SHALL never go below 1 through shifting; exp_i=0 SHALL pass through unshifted.
REQ-030 The count and exponent arithmetic SHALL NOT wrap, because the clamps in REQ-021 guarantee this.

Reset
REQ-031 When rst_i=1, the state SHALL go to IDLE immediately, independent of clk_i.
REQ-032 When rst_i=1, the mantissa, exponent, count, zero and underflow registers SHALL be cleared to 0.
REQ-033 During reset, valid_o SHALL be 0 and ready_o SHALL be 1.
REQ-034 A reset that arrives in SHIFT or DONE SHALL discard the operand in flight, and no result SHALL be produced for it.

Structure
REQ-035 A shared package fp_norm_pkg SHALL hold the state enum and the default values of DataWidth, ExpWidth and StepShift.
REQ-036 The per-cycle shift SHALL use one instance of barrel_shifter, configured with InputDataWidth=OutputDataWidth=DataWidth and MaxShift=StepShift.
REQ-037 The leading-zero count and the step selection SHALL be combinational logic inside norm_shift_ctrl.

Verification
REQ-038 mant_i=0x000001, exp_i=100 -> shift passes of 7,7,7,2; valid_o asserts 5 cycles after accept; mant_o=0x800000, exp_o=77, shift_count_o=23, zero_o=0, underflow_o=0.
REQ-039 mant_i=0x800000, exp_i=127 -> valid_o asserts 1 cycle after accept; outputs unchanged; shift_count_o=0.
REQ-040 mant_i=0x000100, exp_i=5 -> mant_o=0x001000, exp_o=1, shift_count_o=4, underflow_o=1.
REQ-041 mant_i=0, exp_i=50 -> exp_o=0, zero_o=1, shift_count_o=0, valid_o asserts 1 cycle after accept.
REQ-042 ready_i held at 0 for 10 cycles in DONE -> outputs stable and ready_o=0 throughout; ready_i=1 -> IDLE on the next edge with ready_o=1.
REQ-043 rst_i pulsed mid-SHIFT, then a new operand mant_i=0x400000, exp_i=10 -> no stale result is produced; mant_o=0x800000, exp_o=9.

Source files
------------

// File: rtl/fp_norm_pkg.sv
// Shared definitions for the mantissa normalizer: FSM states and default widths.
package fp_norm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DefDataWidth = 24;
  localparam int DefExpWidth  = 8;
  localparam int DefStepShift = 7;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logarithmic left shifter; shift_i must not exceed MaxShift.
module barrel_shifter #(
  parameter int InputDataWidth  = 24,
  parameter int OutputDataWidth = 24,
  parameter int MaxShift        = 7
) (
  input  logic [InputDataWidth-1:0]      data_i,
  input  logic [$clog2(MaxShift+1)-1:0]  shift_i,
  output logic [OutputDataWidth-1:0]     data_o
);

  localparam int ShW = $clog2(MaxShift + 1);

  logic [OutputDataWidth-1:0] stage [ShW+1];

  assign stage[0] = OutputDataWidth'(data_i);

  // Stage gi conditionally shifts by 2**gi.
  for (genvar gi = 0; gi < ShW; gi++) begin : g_stage
    assign stage[gi+1] = shift_i[gi] ? (stage[gi] << (2 ** gi)) : stage[gi];
  end

  assign data_o = stage[ShW];

endmodule

// File: rtl/norm_shift_ctrl.sv
// Multi-cycle mantissa normalizer: shifts left up to StepShift bits per cycle,
// never letting the exponent fall below 1.
module norm_shift_ctrl
  import fp_norm_pkg::*;
#(
  parameter int DataWidth = DefDataWidth,
  parameter int ExpWidth  = DefExpWidth,
  parameter int StepShift = DefStepShift
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [DataWidth-1:0]           mant_i,
  input  logic [ExpWidth-1:0]            exp_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [DataWidth-1:0]           mant_o,
  output logic [ExpWidth-1:0]            exp_o,
  output logic [$clog2(DataWidth+1)-1:0] shift_count_o,
  output logic                           zero_o,
  output logic                           underflow_o
);

  localparam int ShW  = $clog2(StepShift + 1);
  localparam int CntW = $clog2(DataWidth + 1);

  state_t              state;
  logic [DataWidth-1:0] mant;
  logic [ExpWidth-1:0]  expo;
  logic [CntW-1:0]      count;
  logic                 zero;
  logic                 underflow;

  logic [CntW-1:0]      lz;
  logic [ShW-1:0]       step;
  logic [DataWidth-1:0] shifted;

  // Scan from LSB upward so the highest set bit wins.
  always_comb begin
    lz = CntW'(DataWidth);
    for (int i = 0; i < DataWidth; i++) begin
      if (mant[i]) lz = CntW'(DataWidth - 1 - i);
    end
  end

  always_comb begin
    int lim;
    lim = StepShift;
    if (int'(lz) < lim) lim = int'(lz);
    if (expo == '0) lim = 0;
    else if (int'(expo) - 1 < lim) lim = int'(expo) - 1;
    step = ShW'(lim);
  end

  barrel_shifter #(
    .InputDataWidth (DataWidth),
    .OutputDataWidth(DataWidth),
    .MaxShift       (StepShift)
  ) u_shift (
    .data_i (mant),
    .shift_i(step),
    .data_o (shifted)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      mant      <= '0;
      expo      <= '0;
      count     <= '0;
      zero      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            mant      <= mant_i;
            expo      <= exp_i;
            count     <= '0;
            zero      <= 1'b0;
            underflow <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (mant == '0) begin
            expo  <= '0;
            zero  <= 1'b1;
            state <= DONE;
          end else if (step != '0) begin
            mant  <= shifted;
            expo  <= expo - ExpWidth'(step);
            count <= count + CntW'(step);
          end else begin
            // Stopped with MSB clear means the exponent clamp ended normalization.
            underflow <= ~mant[DataWidth-1];
            state     <= DONE;
          end
        end
        DONE: begin
          if (ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o       = (state == IDLE);
  assign valid_o       = (state == DONE);
  assign mant_o        = mant;
  assign exp_o         = expo;
  assign shift_count_o = count;
  assign zero_o        = zero;
  assign underflow_o   = underflow;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Randomized bench for norm_shift_ctrl against a closed-form normalization model.
module tb_norm_shift_ctrl;

  localparam int DW = 24;
  localparam int EW = 8;
  localparam int SS = 7;
  localparam int CW = $clog2(DW + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] mant_i = '0;
  logic [EW-1:0] exp_i = '0;
  logic          valid_o;
  logic          ready_i = 1'b0;
  logic [DW-1:0] mant_o;
  logic [EW-1:0] exp_o;
  logic [CW-1:0] shift_count_o;
  logic          zero_o;
  logic          underflow_o;

  norm_shift_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .mant_i       (mant_i),
    .exp_i        (exp_i),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .mant_o       (mant_o),
    .exp_o        (exp_o),
    .shift_count_o(shift_count_o),
    .zero_o       (zero_o),
    .underflow_o  (underflow_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int passed = 0;

  // Model expectations for the operand in flight.
  bit          pending = 0;
  int          cyc = 0;
  logic [DW-1:0] m_mant;
  logic [EW-1:0] m_exp;
  int          m_cnt;
  bit          m_zero;
  bit          m_uf;
  int          m_lat;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Total shift is bounded by the leading zeros and by keeping the exponent >= 1.
  task automatic model(input logic [DW-1:0] m, input logic [EW-1:0] e);
    int lz, s;
    lz = DW;
    for (int i = DW - 1; i >= 0; i--) begin
      if (m[i]) begin
        lz = DW - 1 - i;
        break;
      end
    end
    if (m == 0) begin
      m_mant = 0; m_exp = 0; m_cnt = 0; m_zero = 1; m_uf = 0; m_lat = 1;
    end else begin
      s = (e == 0) ? 0 : ((int'(e) - 1 < lz) ? int'(e) - 1 : lz);
      m_mant = m << s;
      m_exp  = e - EW'(s);
      m_cnt  = s;
      m_zero = 0;
      m_uf   = ~m_mant[DW-1];
      m_lat  = (s + SS - 1) / SS + 1;
    end
  endtask

  always @(negedge clk_i) begin
    if (pending) begin
      chk("ready_busy", ready_o, 0);
      chk("valid_timing", valid_o, (cyc >= m_lat) ? 1 : 0);
      if (valid_o) begin
        chk("mant", mant_o, m_mant);
        chk("exp", exp_o, m_exp);
        chk("count", shift_count_o, m_cnt);
        chk("zero", zero_o, m_zero);
        chk("underflow", underflow_o, m_uf);
      end
      cyc++;
    end else begin
      chk("idle_ready", ready_o, 1);
      chk("idle_valid", valid_o, 0);
    end
  end

  task automatic accept(input logic [DW-1:0] m, input logic [EW-1:0] e);
    @(negedge clk_i);
    valid_i = 1'b1;
    mant_i  = m;
    exp_i   = e;
    model(m, e);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    mant_i  = $urandom();
    exp_i   = $urandom();
    cyc     = 0;
    pending = 1;
  endtask

  task automatic run_op(input logic [DW-1:0] m, input logic [EW-1:0] e, input int hold,
                        input bit lit, input logic [DW-1:0] l_mant, input logic [EW-1:0] l_exp,
                        input int l_cnt, input bit l_zero, input bit l_uf, input int l_lat);
    int k;
    accept(m, e);
    k = 0;
    @(negedge clk_i);
    while (!valid_o && k < 40) begin
      k++;
      @(negedge clk_i);
    end
    if (k >= 40) begin
      chk("valid_timeout", 0, 1);
      pending = 0;
      rst_i = 1'b1;
      @(negedge clk_i);
      rst_i = 1'b0;
      return;
    end
    if (lit) begin
      chk("lit_latency", k, l_lat);
      chk("lit_mant", mant_o, l_mant);
      chk("lit_exp", exp_o, l_exp);
      chk("lit_count", shift_count_o, l_cnt);
      chk("lit_zero", zero_o, l_zero);
      chk("lit_underflow", underflow_o, l_uf);
    end
    repeat (hold) @(negedge clk_i);
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    ready_i = 1'b0;
    pending = 0;
    chk("release_ready", ready_o, 1);
    chk("release_valid", valid_o, 0);
    $display("op mant=%06h exp=%0d -> mant=%06h exp=%0d cnt=%0d zero=%0b uf=%0b lat=%0d",
             m, e, m_mant, m_exp, m_cnt, m_zero, m_uf, k);
  endtask

  initial begin
    #2;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_mant", mant_o, 0);
    chk("rst_exp", exp_o, 0);
    chk("rst_count", shift_count_o, 0);
    chk("rst_flags", {zero_o, underflow_o}, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    run_op(24'h000001, 8'd100, 0, 1, 24'h800000, 8'd77, 23, 0, 0, 5);
    run_op(24'h800000, 8'd127, 1, 1, 24'h800000, 8'd127, 0, 0, 0, 1);
    run_op(24'h000100, 8'd5,   2, 1, 24'h001000, 8'd1,  4, 0, 1, 2);
    run_op(24'h000000, 8'd50,  0, 1, 24'h000000, 8'd0,  0, 1, 0, 1);
    run_op(24'h000010, 8'd0,   0, 1, 24'h000010, 8'd0,  0, 0, 1, 1);
    run_op(24'h00ABCD, 8'd200, 10, 1, 24'hABCD00, 8'd192, 8, 0, 0, 3);

    // Reset mid-SHIFT discards the operand; next operand must be clean.
    accept(24'h000001, 8'd100);
    repeat (2) @(posedge clk_i);
    #3;
    pending = 0;
    rst_i = 1'b1;
    #1;
    chk("async_rst_ready", ready_o, 1);
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_mant", mant_o, 0);
    chk("async_rst_count", shift_count_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    $display("reset pulsed mid-shift");
    run_op(24'h400000, 8'd10, 0, 1, 24'h800000, 8'd9, 1, 0, 0, 2);

    for (int n = 0; n < 200; n++) begin
      logic [DW-1:0] rm;
      logic [EW-1:0] re;
      rm = DW'($urandom()) >> $urandom_range(0, DW);
      case ($urandom_range(0, 3))
        0: re = EW'($urandom_range(0, 8));
        1: re = EW'($urandom_range(9, 30));
        default: re = EW'($urandom());
      endcase
      run_op(rm, re, $urandom_range(0, 3), 0, '0, '0, 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
